pps_raw_capture: RTL and testbench



---
 rtl/pps_raw_capture_if.sv | 13 +
 rtl/pps_raw_capture.sv | 194 +++++++++++++++++++
 tb/tb_pps_raw_capture.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pps_raw_capture_if.sv
// Raw ADC sample bus feeding the PPS capture stage: one I/Q pair plus its qualifier.
// adc_valid qualifies adc_i/adc_q in the same cycle. There is no ready: the consumer
// takes a sample only when it is armed, and samples offered at other times are dropped.
interface pps_raw_capture_if #(
    parameter int ADC_W = 12
);
    logic [ADC_W-1:0] adc_i;
    logic [ADC_W-1:0] adc_q;
    logic             adc_valid;

    modport master (output adc_i, output adc_q, output adc_valid);
    modport slave  (input  adc_i, input  adc_q, input  adc_valid);
endinterface

// File: rtl/pps_raw_capture.sv
// Synchronizes PPS, measures its period and grabs the first valid raw I/Q sample after
// each accepted edge, packing sample, sequence and health flags into user_data_out.
module pps_raw_capture #(
    parameter int          ADC_W          = 12,
    parameter int unsigned NOM_PERIOD     = 256000000,
    parameter int unsigned TOL            = 1000,
    parameter int unsigned SAMPLE_TIMEOUT = 16
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             pps_in,
    input  logic             enable,
    pps_raw_capture_if.slave adc,
    output logic [31:0]      user_data_out,
    output logic [31:0]      period_out,
    output logic [31:0]      pps_count,
    output logic             pps_pulse,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TW = $clog2(SAMPLE_TIMEOUT + 1) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          s1;
    logic          s2;
    logic          s3;
    logic [31:0]   cnt;
    logic [31:0]   dev;
    logic          first_seen;
    logic          period_ok;
    logic          period_ok_nxt;
    logic          overrun;
    logic [TW-1:0] timer;
    logic          timer_hit;
    logic          cap_sample;
    logic          cap_timeout;
    logic          timer_load;
    logic          ovr_set;
    logic [3:0]    seq_pack;
    logic          ok_pack;
    logic          ovr_pack;
    logic [11:0]   i12;
    logic [11:0]   q12;

    // PPS synchronizer; s3 is the previous sample used for rising-edge detection.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pps_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pps_pulse = s2 & ~s3 & enable;

    assign dev           = (cnt >= NOM_PERIOD) ? (cnt - NOM_PERIOD) : (NOM_PERIOD - cnt);
    assign period_ok_nxt = first_seen & (dev <= TOL);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            cnt        <= 32'd0;
            period_out <= 32'd0;
            pps_count  <= 32'd0;
            first_seen <= 1'b0;
            period_ok  <= 1'b0;
        end else if (pps_pulse) begin
            cnt        <= 32'd1;
            period_out <= cnt;
            pps_count  <= pps_count + 32'd1;
            first_seen <= 1'b1;
            period_ok  <= period_ok_nxt;
        end else if (cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
        end
    end

    // A capture in the pulse cycle must report the values that pulse is about to commit.
    assign seq_pack = pps_count[3:0] + {3'd0, pps_pulse};
    assign ok_pack  = pps_pulse ? period_ok_nxt : period_ok;
    assign ovr_pack = overrun | ovr_set;

    generate
        if (ADC_W >= 12) begin : g_adc_msb
            assign i12 = adc.adc_i[ADC_W-1 -: 12];
            assign q12 = adc.adc_q[ADC_W-1 -: 12];
        end else begin : g_adc_zext
            assign i12 = {{(12 - ADC_W){1'b0}}, adc.adc_i};
            assign q12 = {{(12 - ADC_W){1'b0}}, adc.adc_q};
        end
    endgenerate

    assign timer_hit = (timer == TW'(SAMPLE_TIMEOUT));
    assign state_dbg = state;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // With enable low the FSM stays put; a pulse in DONE is treated exactly like IDLE.
    always_comb begin
        state_nxt = state;
        if (enable) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (pps_pulse) begin
                        state_nxt = adc.adc_valid ? ST_DONE : ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (adc.adc_valid || (!pps_pulse && timer_hit)) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cap_sample  = 1'b0;
        cap_timeout = 1'b0;
        timer_load  = 1'b0;
        ovr_set     = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (pps_pulse) begin
                        cap_sample = adc.adc_valid;
                        timer_load = ~adc.adc_valid;
                    end
                end
                ST_WAIT: begin
                    if (pps_pulse) begin
                        ovr_set    = 1'b1;
                        cap_sample = adc.adc_valid;
                        timer_load = ~adc.adc_valid;
                    end else if (adc.adc_valid) begin
                        cap_sample = 1'b1;
                    end else if (timer_hit) begin
                        cap_timeout = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer holds cycles since the arming pulse: 1 in the first WAIT cycle.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= TW'(1);
        end else if (enable && (state == ST_WAIT) && !timer_hit) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            user_data_out <= 32'd0;
            overrun       <= 1'b0;
        end else begin
            if (cap_sample || cap_timeout) begin
                user_data_out <= {seq_pack, cap_timeout, ok_pack, ovr_pack, 1'b1,
                                  cap_timeout ? 12'd0 : i12,
                                  cap_timeout ? 12'd0 : q12};
            end
            if (cap_sample) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pps_raw_capture.sv
// Bench for pps_raw_capture: directed test-plan scenarios plus randomized PPS/ADC traffic,
// every cycle compared against an event/timestamp model of the capture rules.
module tb_pps_raw_capture;

    localparam int ADC_W = 12;
    localparam int NOM   = 100;
    localparam int TOL   = 2;
    localparam int TO    = 4;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        pps_in   = 1'b0;
    logic        enable   = 1'b0;
    logic [31:0] user_data_out;
    logic [31:0] period_out;
    logic [31:0] pps_count;
    logic        pps_pulse;
    logic [1:0]  state_dbg;

    pps_raw_capture_if #(.ADC_W(ADC_W)) bus ();

    pps_raw_capture #(
        .ADC_W(ADC_W), .NOM_PERIOD(NOM), .TOL(TOL), .SAMPLE_TIMEOUT(TO)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst), .pps_in(pps_in), .enable(enable),
        .adc(bus), .user_data_out(user_data_out), .period_out(period_out),
        .pps_count(pps_count), .pps_pulse(pps_pulse), .state_dbg(state_dbg)
    );

    always #5 user_clk = ~user_clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: timestamps in cycles rather than counters.
    longint      now      = 0;
    longint      ref_t    = 0;
    longint      deadline = 0;
    bit          h1, h2, h3;
    bit          seen, ok_m, pending, ovr_m;
    logic [31:0] period_m, count_m, udo_m;

    // Observation of the DUT for latency/count checks.
    longint      dut_pulse_t   = 0;
    longint      udo_change_t  = 0;
    logic [31:0] udo_prev      = 32'd0;
    int          dut_pulses    = 0;
    int          udo_changes   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, now, got, exp);
        end
    endtask

    task automatic capture_m(input bit to);
        udo_m = {count_m[3:0], to, ok_m, ovr_m, 1'b1,
                 to ? 12'd0 : bus.adc_i, to ? 12'd0 : bus.adc_q};
        if (!to) ovr_m = 1'b0;
        pending = 1'b0;
    endtask

    task automatic model_cycle();
        bit     exp_pulse;
        longint d;
        exp_pulse = h2 && !h3 && enable;
        if (pps_pulse) begin
            dut_pulse_t = now;
            dut_pulses++;
        end
        if (user_data_out !== udo_prev) begin
            udo_change_t = now;
            udo_changes++;
        end
        udo_prev = user_data_out;
        check("pps_pulse", {31'd0, pps_pulse}, {31'd0, exp_pulse});
        check("user_data_out", user_data_out, udo_m);
        check("period_out", period_out, period_m);
        check("pps_count", pps_count, count_m);

        if (user_rst) begin
            udo_m = 0; period_m = 0; count_m = 0;
            seen = 0; ok_m = 0; pending = 0; ovr_m = 0;
            ref_t = now + 1;
        end else if (exp_pulse) begin
            period_m = 32'(now - ref_t);
            d = (now - ref_t) - NOM;
            if (d < 0) d = -d;
            ok_m    = seen && (d <= TOL);
            seen    = 1'b1;
            count_m = count_m + 1;
            ref_t   = now;
            if (pending) ovr_m = 1'b1;
            if (bus.adc_valid) capture_m(1'b0);
            else begin
                pending  = 1'b1;
                deadline = now + TO;
            end
        end else if (pending) begin
            if (!enable) deadline++;
            else if (bus.adc_valid) capture_m(1'b0);
            else if (now == deadline) capture_m(1'b1);
        end

        h3 = h2; h2 = h1; h1 = pps_in;
        if (user_rst) begin
            h1 = 0; h2 = 0; h3 = 0;
        end
        now++;
    endtask

    task automatic step(input logic p, input logic e, input logic v,
                        input logic [11:0] i, input logic [11:0] q, input logic r);
        pps_in = p; enable = e; user_rst = r;
        bus.adc_valid = v; bus.adc_i = i; bus.adc_q = q;
        @(negedge user_clk);
        model_cycle();
        @(posedge user_clk);
        #1;
    endtask

    task automatic pps_edge(input int gap, input int width, input logic v);
        for (int c = 0; c < gap; c++) step(c < width, 1'b1, v, 12'hABC, 12'h123, 1'b0);
    endtask

    initial begin
        int p0, c0, gap, w;
        bus.adc_valid = 1'b0; bus.adc_i = '0; bus.adc_q = '0;
        seen = 0; ok_m = 0; pending = 0; ovr_m = 0;
        h1 = 0; h2 = 0; h3 = 0;
        period_m = 0; count_m = 0; udo_m = 0;
        repeat (3) @(posedge user_clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1);
        check("rst_udo", user_data_out, 32'd0);
        check("rst_period", period_out, 32'd0);
        check("rst_count", pps_count, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, 12'hABC, 12'h123, 1'b0);

        // Nominal and off-nominal periods with adc_valid tied high.
        pps_edge(100, 10, 1'b1);
        check("seq1_word", user_data_out, 32'h11ABC123);
        pps_edge(103, 10, 1'b1);
        check("seq2_word", user_data_out, 32'h25ABC123);
        check("seq2_period", period_out, 32'd100);
        pps_edge(98, 10, 1'b1);
        check("p103_word", user_data_out, 32'h31ABC123);
        check("p103_period", period_out, 32'd103);
        pps_edge(100, 10, 1'b1);
        check("p98_word", user_data_out, 32'h45ABC123);
        check("p98_period", period_out, 32'd98);

        // Timeout with adc_valid held low.
        pps_edge(100, 10, 1'b0);
        check("timeout_word", user_data_out, 32'h5D000000);
        check("timeout_latency", 32'(udo_change_t - dut_pulse_t), 32'd5);

        // Overrun: second edge 3 cycles after the first, valid 2 cycles after that pulse.
        c0 = udo_changes;
        for (int c = 0; c < 40; c++)
            step((c == 0) || (c == 3), 1'b1, (c == 7), 12'hABC, 12'h123, 1'b0);
        check("ovr_word", user_data_out, 32'h73ABC123);
        check("ovr_count", pps_count, 32'd7);
        check("ovr_captures", 32'(udo_changes - c0), 32'd1);

        // Wide PPS pulse.
        p0 = dut_pulses;
        pps_edge(120, 50, 1'b1);
        check("wide_pulses", 32'(dut_pulses - p0), 32'd1);
        check("wide_count", pps_count, 32'd8);

        // Edge while disabled.
        p0 = dut_pulses;
        for (int c = 0; c < 30; c++) step(c < 10, c >= 8, 1'b1, 12'h555, 12'hAAA, 1'b0);
        check("dis_pulses", 32'(dut_pulses - p0), 32'd0);
        check("dis_count", pps_count, 32'd8);

        // Reset while waiting for a sample.
        for (int c = 0; c < 4; c++) step(c < 2, 1'b1, 1'b0, 12'h321, 12'h654, c == 3);
        check("rstw_udo", user_data_out, 32'd0);
        check("rstw_period", period_out, 32'd0);
        check("rstw_count", pps_count, 32'd0);
        for (int c = 0; c < 30; c++) step(1'b0, 1'b1, (c > 10), 12'h321, 12'h654, 1'b0);
        check("rstw_no_update", user_data_out, 32'd0);

        // Randomized traffic: periods around nominal and short bursts, random valid/enable/reset.
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 1) == 1) gap = $urandom_range(NOM - 4, NOM + 4);
            else gap = $urandom_range(3, 130);
            w = $urandom_range(1, gap - 1);
            for (int c = 0; c < gap; c++)
                step(c < w, $urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0,
                     12'($urandom), 12'($urandom), $urandom_range(0, 599) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
